// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and helpers for the ping-pong FFT frame scheduler.
package fft_frame_scheduler_pkg;

  localparam int FFT_BW   = 29;
  localparam int FFT_N    = 16;
  localparam int FFT_SIZE = 4;

  // Life cycle of one sample bank.
  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_BUSY    = 2'd3
  } bank_state_t;

  // Engine hand-off sequence towards the FFT core.
  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_START = 2'd1,
    E_RUN   = 2'd2
  } eng_state_t;

  // Reverse the low w bits of a; bits at and above w come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] a, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_bank_state.sv
// Per-bank state tracker: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
module fft_bank_state
  import fft_frame_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill_start,
  input  logic        fill_done,
  input  logic        grant,
  input  logic        bank_release,
  output bank_state_t state,
  output logic        full
);

  // Advance the bank through its cycle; each event is honoured only in the
  // state where it makes sense, so a stray strobe cannot skip a stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= B_EMPTY;
    end else begin
      case (state)
        B_EMPTY: begin
          if (fill_done)       state <= B_FULL;
          else if (fill_start) state <= B_FILLING;
        end
        B_FILLING: if (fill_done)    state <= B_FULL;
        B_FULL:    if (grant)        state <= B_BUSY;
        B_BUSY:    if (bank_release) state <= B_EMPTY;
        default:                     state <= B_EMPTY;
      endcase
    end
  end

  // Full flag feeds the oldest-first selector.
  always_comb full = (state == B_FULL);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame scheduler: loads bit-reversed frames into two banks and
// hands each full bank to the sequential FFT core.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on registered state, so it may
// be used to decide in_valid without a combinational loop; the source must
// hold in_re/in_im stable while in_valid is high and in_ready is low.
module fft_frame_scheduler
  import fft_frame_scheduler_pkg::*;
#(
  parameter int bit_width = FFT_BW,
  parameter int N         = FFT_N,
  parameter int SIZE      = FFT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bit_width-1:0] in_re,
  input  logic [bit_width-1:0] in_im,
  output logic                 ld_we,
  output logic                 ld_bank,
  output logic [SIZE-1:0]      ld_addr,
  output logic [bit_width-1:0] ld_re,
  output logic [bit_width-1:0] ld_im,
  output logic                 start_fft,
  output logic                 eng_bank,
  input  logic                 eng_done,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 err_done
);

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  logic            run;
  logic            fill_bank;
  logic [SIZE-1:0] wr_cnt;
  logic            oldest;
  bank_state_t     st0;
  bank_state_t     st1;
  bank_state_t     fill_st;
  logic [1:0]      bank_full;
  logic [1:0]      fill_start;
  logic [1:0]      fill_done;
  logic [1:0]      grant;
  logic [1:0]      bank_rel;
  logic            accept;
  logic            frame_last;
  eng_state_t      eng_state;
  eng_state_t      eng_next;
  logic            grant_v;
  logic            grant_bank;
  logic            rel_v;

  fft_bank_state u_bank0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_start   (fill_start[0]),
    .fill_done    (fill_done[0]),
    .grant        (grant[0]),
    .bank_release (bank_rel[0]),
    .state        (st0),
    .full         (bank_full[0])
  );

  fft_bank_state u_bank1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_start   (fill_start[1]),
    .fill_done    (fill_done[1]),
    .grant        (grant[1]),
    .bank_release (bank_rel[1]),
    .state        (st1),
    .full         (bank_full[1])
  );

  // Loader handshake and per-bank event strobes.
  always_comb begin
    fill_st       = fill_bank ? st1 : st0;
    in_ready      = run && ((fill_st == B_EMPTY) || (fill_st == B_FILLING));
    accept        = in_valid && in_ready;
    frame_last    = accept && (wr_cnt == LAST_IDX);
    fill_start[0] = accept && !fill_bank;
    fill_start[1] = accept && fill_bank;
    fill_done[0]  = frame_last && !fill_bank;
    fill_done[1]  = frame_last && fill_bank;
    grant[0]      = grant_v && !grant_bank;
    grant[1]      = grant_v && grant_bank;
    bank_rel[0]   = rel_v && !eng_bank;
    bank_rel[1]   = rel_v && eng_bank;
  end

  // in_ready stays low while reset is applied and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Loader: register each accepted sample with its bit-reversed address and
  // swap to the other bank after the last sample of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_we     <= 1'b0;
      ld_bank   <= 1'b0;
      ld_addr   <= '0;
      ld_re     <= '0;
      ld_im     <= '0;
      wr_cnt    <= '0;
      fill_bank <= 1'b0;
    end else begin
      ld_we <= accept;
      if (accept) begin
        ld_bank <= fill_bank;
        ld_addr <= SIZE'(bitrev(16'(wr_cnt), SIZE));
        ld_re   <= in_re;
        ld_im   <= in_im;
        wr_cnt  <= wr_cnt + 1'b1;
        if (frame_last) fill_bank <= ~fill_bank;
      end
    end
  end

  // Engine state register, bank ownership, fill-order bit and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_state <= E_IDLE;
      eng_bank  <= 1'b0;
      oldest    <= 1'b0;
      frame_cnt <= '0;
      err_done  <= 1'b0;
    end else begin
      eng_state <= eng_next;
      if (grant_v) begin
        eng_bank <= grant_bank;
        oldest   <= ~grant_bank;
      end
      if (rel_v) frame_cnt <= frame_cnt + 16'd1;
      if (eng_done && (eng_state != E_RUN)) err_done <= 1'b1;
    end
  end

  // Engine next-state and outputs; the bank that completed first is served first.
  always_comb begin
    eng_next   = eng_state;
    grant_v    = 1'b0;
    grant_bank = oldest;
    rel_v      = 1'b0;
    start_fft  = 1'b0;
    busy       = 1'b0;
    case (eng_state)
      E_IDLE: begin
        if (bank_full[oldest]) begin
          grant_v    = 1'b1;
          grant_bank = oldest;
          eng_next   = E_START;
        end else if (bank_full[~oldest]) begin
          grant_v    = 1'b1;
          grant_bank = ~oldest;
          eng_next   = E_START;
        end
      end
      E_START: begin
        start_fft = 1'b1;
        busy      = 1'b1;
        eng_next  = E_RUN;
      end
      E_RUN: begin
        busy = 1'b1;
        if (eng_done) begin
          rel_v    = 1'b1;
          eng_next = E_IDLE;
        end
      end
      default: eng_next = E_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: randomized streams checked cycle by cycle
// against a frame-level reference model of the scheduler.
module tb_fft_frame_scheduler;

  localparam int BW = 29;
  localparam int NP = 16;
  localparam int EW = 1 + 4 + BW + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_re = '0;
  logic [BW-1:0] in_im = '0;
  logic          ld_we;
  logic          ld_bank;
  logic [3:0]    ld_addr;
  logic [BW-1:0] ld_re;
  logic [BW-1:0] ld_im;
  logic          start_fft;
  logic          eng_bank;
  logic          eng_done = 1'b0;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_done;

  fft_frame_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .ld_we     (ld_we),
    .ld_bank   (ld_bank),
    .ld_addr   (ld_addr),
    .ld_re     (ld_re),
    .ld_im     (ld_im),
    .start_fft (start_fft),
    .eng_bank  (eng_bank),
    .eng_done  (eng_done),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_done  (err_done)
  );

  // ---------------- reference model state ----------------
  int            n_vec = 0;
  int            n_miss = 0;
  bit            mon_en = 0;
  int            k;            // accepts since reset
  bit            occ [2];      // bank holds a frame not yet finished by the core
  int            frame_q[$];   // completed frames waiting for start, oldest first
  logic [EW-1:0] exp_q[$];     // expected load-port writes
  logic [EW-1:0] last_ld;
  bit            running;
  int            run_bank;
  int            exp_frames;
  bit            exp_err;
  bit            prev_acc;
  int            start_due;
  int            start_cnt;
  int            ld_cnt;
  bit            auto_done = 0;
  int            done_lat = 40;
  int            done_timer;
  int            man_req = 0;
  int            man_seen = 0;

  function automatic logic [3:0] ref_bitrev(input int v);
    logic [3:0] a;
    a = v[3:0];
    return {a[0], a[1], a[2], a[3]};
  endfunction

  task automatic model_clear();
    k = 0;
    occ[0] = 0;
    occ[1] = 0;
    frame_q.delete();
    exp_q.delete();
    last_ld = '0;
    running = 0;
    run_bank = 0;
    exp_frames = 0;
    exp_err = 0;
    prev_acc = 0;
    start_due = 0;
    start_cnt = 0;
    ld_cnt = 0;
    done_timer = 0;
    man_seen = man_req;
    eng_done = 1'b0;
  endtask

  // Called at the falling edge of every cycle: checks what the DUT shows in
  // this cycle, then advances the model to the next cycle.
  task automatic monitor_cycle();
    logic [EW-1:0] e;
    logic [EW-1:0] obs;
    bit exp_rdy;
    bit start_now;
    bit idle_now;
    bit acc;
    int b;
    if (start_due > 0) begin
      start_due--;
      if (start_due == 0) begin
        n_vec++;
        if (start_fft !== 1'b1) begin
          n_miss++;
          $display("FAIL start_latency: start_fft=%b required 1 two cycles after last accept", start_fft);
        end
      end
    end
    obs = {ld_bank, ld_addr, ld_re, ld_im};
    n_vec++;
    if (ld_we !== prev_acc) begin
      n_miss++;
      $display("FAIL ld_we: got %b required %b", ld_we, prev_acc);
    end
    if (ld_we === 1'b1) begin
      ld_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL ld_extra: write bank=%0d addr=%0d with nothing expected", ld_bank, ld_addr);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_miss++;
          $display("FAIL ld_data: got bank=%0d addr=%0d re=%h im=%h required bank=%0d addr=%0d re=%h im=%h",
                   obs[EW-1], obs[EW-2 -: 4], obs[2*BW-1 -: BW], obs[BW-1:0],
                   e[EW-1], e[EW-2 -: 4], e[2*BW-1 -: BW], e[BW-1:0]);
        end
      end
      last_ld = obs;
    end else begin
      n_vec++;
      if (obs !== last_ld) begin
        n_miss++;
        $display("FAIL ld_hold: got %h required %h", obs, last_ld);
      end
    end
    exp_rdy = !occ[k[4]];
    n_vec++;
    if (in_ready !== exp_rdy) begin
      n_miss++;
      $display("FAIL in_ready: got %b required %b (accepts=%0d)", in_ready, exp_rdy, k);
    end
    start_now = (start_fft === 1'b1);
    if (start_now) begin
      start_cnt++;
      n_vec++;
      if (frame_q.size() == 0) begin
        n_miss++;
        $display("FAIL start_spurious: start_fft with no complete frame waiting");
      end else begin
        b = frame_q.pop_front();
        if (eng_bank !== b[0]) begin
          n_miss++;
          $display("FAIL start_bank: eng_bank=%b required %0d", eng_bank, b);
        end
        running = 1;
        run_bank = b;
        if (auto_done) done_timer = done_lat;
      end
    end
    n_vec++;
    if (busy !== running) begin
      n_miss++;
      $display("FAIL busy: got %b required %b", busy, running);
    end
    n_vec++;
    if (err_done !== exp_err) begin
      n_miss++;
      $display("FAIL err_done: got %b required %b", err_done, exp_err);
    end
    n_vec++;
    if (frame_cnt !== 16'(exp_frames)) begin
      n_miss++;
      $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
    end
    if (running) begin
      n_vec++;
      if (eng_bank !== run_bank[0]) begin
        n_miss++;
        $display("FAIL eng_bank_hold: got %b required %0d", eng_bank, run_bank);
      end
    end
    idle_now = !running && (frame_q.size() == 0);
    // Core emulation: eng_done set now is sampled at the end of this cycle.
    eng_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) eng_done = 1'b1;
    end
    if (man_req != man_seen) begin
      man_seen = man_req;
      eng_done = 1'b1;
    end
    if (eng_done) begin
      if (running && !start_now) begin
        running = 0;
        exp_frames++;
        occ[run_bank] = 0;
      end else begin
        exp_err = 1;
      end
    end
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    prev_acc = acc;
    if (acc) begin
      exp_q.push_back({k[4], ref_bitrev(k % NP), in_re, in_im});
      if ((k % NP) == NP - 1) begin
        if (idle_now) start_due = 2;
        frame_q.push_back(int'(k[4]));
        occ[k[4]] = 1;
      end
      k++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor_cycle();
    else        model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1;
  endtask

  // Offer n samples with in_valid asserted pct% of cycles; values hold until taken.
  task automatic send(input int n, input int pct, input bit seq);
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    in_re = seq ? BW'(0) : BW'($urandom());
    in_im = BW'($urandom());
    while (sent < n && guard < 4000) begin
      in_valid = ($urandom_range(99) < pct);
      tick();
      guard++;
      if (prev_acc) begin
        sent++;
        in_re = seq ? BW'(sent) : BW'($urandom());
        in_im = BW'($urandom());
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (sent != n) begin
      n_miss++;
      $display("FAIL send_timeout: accepted %0d required %0d", sent, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((running || frame_q.size() != 0 || exp_q.size() != 0 || start_due != 0) && t < budget) begin
      tick();
      t++;
    end
    n_vec++;
    if (t >= budget) begin
      n_miss++;
      $display("FAIL idle_timeout: engine still active after %0d cycles", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mon_en = 0;
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({in_ready, ld_we, ld_bank, start_fft, eng_bank, busy, err_done} !== 7'b0) begin
      n_miss++;
      $display("FAIL reset_flags: rdy,we,bank,start,eng,busy,err=%b required 0000000",
               {in_ready, ld_we, ld_bank, start_fft, eng_bank, busy, err_done});
    end
    n_vec++;
    if ({ld_addr, ld_re, ld_im, frame_cnt} !== '0) begin
      n_miss++;
      $display("FAIL reset_data: addr=%0d re=%h im=%h frames=%0d required all 0", ld_addr, ld_re, ld_im, frame_cnt);
    end
    rst_n = 1'b1;
    tick();
    mon_en = 1;
    tick();
  endtask

  task automatic test_single_frame();
    do_reset();
    auto_done = 1;
    done_lat = 12;
    send(NP, 100, 1'b1);
    tick();
    tick();
    n_vec++;
    if (eng_bank !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL first_frame: eng_bank=%b busy=%b required 0 1", eng_bank, busy);
    end
    wait_idle(100);
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_done = 1;
    done_lat = 40;
    send(48, 100, 1'b0);
    wait_idle(300);
    n_vec++;
    if (frame_cnt !== 16'd3 || ld_cnt != 48) begin
      n_miss++;
      $display("FAIL stream48: frames=%0d writes=%0d required 3 48", frame_cnt, ld_cnt);
    end
  endtask

  task automatic test_done_idle();
    do_reset();
    auto_done = 0;
    man_req++;
    repeat (3) tick();
    n_vec++;
    if (err_done !== 1'b1 || frame_cnt !== 16'd0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL done_idle: err=%b frames=%0d busy=%b required 1 0 0", err_done, frame_cnt, busy);
    end
    auto_done = 1;
    done_lat = 8;
    send(NP, 100, 1'b0);
    wait_idle(100);
    n_vec++;
    if (err_done !== 1'b1 || frame_cnt !== 16'd1) begin
      n_miss++;
      $display("FAIL err_sticky: err=%b frames=%0d required 1 1", err_done, frame_cnt);
    end
  endtask

  task automatic test_oldest_first();
    do_reset();
    auto_done = 0;
    send(2 * NP, 100, 1'b0);
    repeat (4) tick();
    n_vec++;
    if (eng_bank !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL both_loaded: eng_bank=%b busy=%b in_ready=%b required 0 1 0", eng_bank, busy, in_ready);
    end
    man_req++;
    repeat (4) tick();
    n_vec++;
    if (eng_bank !== 1'b1 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL older_next: eng_bank=%b busy=%b required 1 1", eng_bank, busy);
    end
    send(NP, 100, 1'b0);
    repeat (3) tick();
    n_vec++;
    if (eng_bank !== 1'b1) begin
      n_miss++;
      $display("FAIL eng_bank_held: eng_bank=%b required 1", eng_bank);
    end
    man_req++;
    repeat (4) tick();
    man_req++;
    wait_idle(50);
    n_vec++;
    if (frame_cnt !== 16'd3) begin
      n_miss++;
      $display("FAIL oldest_frames: frames=%0d required 3", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    auto_done = 1;
    done_lat = 10;
    send(7, 100, 1'b1);
    mon_en = 0;
    #3 rst_n = 1'b0;
    tick();
    n_vec++;
    if (ld_we !== 1'b0 || in_ready !== 1'b0 || ld_addr !== 4'd0) begin
      n_miss++;
      $display("FAIL async_reset: ld_we=%b in_ready=%b ld_addr=%0d required 0 0 0", ld_we, in_ready, ld_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1;
    send(NP, 100, 1'b1);
    wait_idle(100);
    n_vec++;
    if (start_cnt != 1 || frame_cnt !== 16'd1) begin
      n_miss++;
      $display("FAIL after_reset: starts=%0d frames=%0d required 1 1", start_cnt, frame_cnt);
    end
  endtask

  task automatic test_random_valid();
    do_reset();
    auto_done = 1;
    done_lat = $urandom_range(30, 5);
    send(4 * NP, 50, 1'b0);
    wait_idle(400);
    n_vec++;
    if (frame_cnt !== 16'd4 || ld_cnt != 4 * NP) begin
      n_miss++;
      $display("FAIL random_valid: frames=%0d writes=%0d required 4 %0d", frame_cnt, ld_cnt, 4 * NP);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_done_idle();
    test_oldest_first();
    test_reset_mid_frame();
    test_random_valid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
